// File: rtl/cpu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl_pkg
// Shared definitions for the v1 CPU sequencer:
//   - RV32 opcode / funct3 constants and the EBREAK encoding
//   - ALU operation codes driven to the datapath
//   - FSM state encoding (3 bits, plain constants for legacy tooling)
//   - ctrl_t: the registered datapath control bundle
//   - next_pc(): sequential PC increment
// -----------------------------------------------------------------------------
package cpu_seq_ctrl_pkg;

   localparam logic [6:0]  OPC_OP_IMM   = 7'b001_0011;
   localparam logic [2:0]  F3_ADDI      = 3'b000;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   localparam logic [2:0]  ALU_OP_NONE  = 3'b000;
   localparam logic [2:0]  ALU_OP_ADD   = 3'b001;

   localparam logic [2:0]  ST_FETCH     = 3'd0;
   localparam logic [2:0]  ST_DECODE    = 3'd1;
   localparam logic [2:0]  ST_EXEC      = 3'd2;
   localparam logic [2:0]  ST_WB        = 3'd3;
   localparam logic [2:0]  ST_HALT      = 3'd4;

   typedef struct packed {
      logic [2:0]  alu_op;
      logic [11:0] imm12;
      logic [4:0]  rs1;
      logic [4:0]  rd;
   } ctrl_t;

   // PC advances by one word and wraps modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] cur_pc);
      return cur_pc + 32'd4;
   endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl_if
// Instruction-memory fetch port (req/ack handshake).
//   req   : fetch request, held with a stable addr until ack or withdrawal
//   addr  : word-aligned fetch address
//   ack   : fetch complete, rdata valid in the same cycle
//   rdata : fetched instruction word
// Modports: master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface cpu_seq_ctrl_if;

   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/cpu_seq_ctrl_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational instruction decoder.
//   ir        in   32  instruction register contents
//   ctrl      out      {alu_op, imm12, rs1, rd} for the instruction
//   is_legal  out  1   instruction is a supported ADDI
//   is_ebreak out  1   instruction is exactly EBREAK
// -----------------------------------------------------------------------------
module instr_decode
   import cpu_seq_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output ctrl_t       ctrl,
   output logic        is_legal,
   output logic        is_ebreak
);

   always_comb begin
      is_ebreak   = (ir == INSTR_EBREAK);
      is_legal    = (ir[6:0] == OPC_OP_IMM) && (ir[14:12] == F3_ADDI);
      ctrl.imm12  = ir[31:20];
      ctrl.rs1    = ir[19:15];
      ctrl.rd     = ir[11:7];
      ctrl.alu_op = is_legal ? ALU_OP_ADD : ALU_OP_NONE;
   end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl
// Multi-cycle sequencer for the v1 CPU. Owns PC and IR, fetches over the imem
// req/ack port, decodes and drives regfile/ALU controls so that each ADDI
// retires with exactly one write-back. EBREAK halts; anything else halts and
// raises illegal.
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   run             allow new fetches
//   imem            fetch port (master side)
//   rf_rs1, rf_rd   register indices
//   rf_we           one-cycle write pulse in WB
//   alu_op, imm12   ALU operation and I-type immediate
//   pc, instret     current PC, retired-instruction count
//   halted, illegal sticky stop flags, cleared only by reset
// FSM: FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT terminal.
// -----------------------------------------------------------------------------
module cpu_seq_ctrl
   import cpu_seq_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   cpu_seq_ctrl_if.master    imem,
   output logic [4:0]        rf_rs1,
   output logic [4:0]        rf_rd,
   output logic              rf_we,
   output logic [2:0]        alu_op,
   output logic [11:0]       imm12,
   output logic [31:0]       pc,
   output logic [CNT_W-1:0]  instret,
   output logic              halted,
   output logic              illegal
);

   logic [2:0]       state_reg;
   logic [31:0]      pc_reg;
   logic [31:0]      ir_reg;
   logic [CNT_W-1:0] instret_reg;
   logic             halted_reg;
   logic             illegal_reg;
   ctrl_t            ctrl_reg;

   ctrl_t            dec_ctrl;
   logic             dec_legal;
   logic             dec_ebreak;
   logic             fetch_req;
   logic             fetch_fire;

   instr_decode u_decode (
      .ir        (ir_reg),
      .ctrl      (dec_ctrl),
      .is_legal  (dec_legal),
      .is_ebreak (dec_ebreak)
   );

   // The request follows run combinationally so that dropping run withdraws
   // a pending fetch in the same cycle; an ack is only honoured while the
   // request is actually presented.
   assign fetch_req  = run && (state_reg == ST_FETCH);
   assign fetch_fire = fetch_req && imem.ack;

   // Reset is folded in so that no request is presented while rst_n is low,
   // even though the state register already reads FETCH.
   assign imem.req   = fetch_req && rst_n;
   assign imem.addr  = {pc_reg[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_FETCH;
         pc_reg      <= RESET_PC;
         ir_reg      <= '0;
         instret_reg <= '0;
         halted_reg  <= 1'b0;
         illegal_reg <= 1'b0;
         ctrl_reg    <= '0;
      end else begin
         case (state_reg)
            ST_FETCH: begin
               if (fetch_fire) begin
                  ir_reg    <= imem.rdata;
                  state_reg <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (dec_ebreak) begin
                  halted_reg <= 1'b1;
                  state_reg  <= ST_HALT;
               end else if (dec_legal) begin
                  ctrl_reg   <= dec_ctrl;
                  state_reg  <= ST_EXEC;
               end else begin
                  halted_reg  <= 1'b1;
                  illegal_reg <= 1'b1;
                  state_reg   <= ST_HALT;
               end
            end
            ST_EXEC: begin
               state_reg <= ST_WB;
            end
            ST_WB: begin
               pc_reg      <= next_pc(pc_reg);
               instret_reg <= instret_reg + 1'b1;
               ctrl_reg    <= '0;
               state_reg   <= ST_FETCH;
            end
            ST_HALT: begin
               state_reg <= ST_HALT;
            end
            default: begin
               // Unused encodings can only arise from an upset; stop safely.
               halted_reg  <= 1'b1;
               illegal_reg <= 1'b1;
               ctrl_reg    <= '0;
               state_reg   <= ST_HALT;
            end
         endcase
      end
   end

   assign rf_we   = (state_reg == ST_WB);
   assign alu_op  = ctrl_reg.alu_op;
   assign imm12   = ctrl_reg.imm12;
   assign rf_rs1  = ctrl_reg.rs1;
   assign rf_rd   = ctrl_reg.rd;
   assign pc      = pc_reg;
   assign instret = instret_reg;
   assign halted  = halted_reg;
   assign illegal = illegal_reg;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_seq_ctrl
// Directed bench for cpu_seq_ctrl. dut0 uses RESET_PC=0, dut1 uses
// RESET_PC=32'hFFFF_FFFC for the wrap and mid-instruction reset cases.
// Inputs change 1 time unit after a rising edge; outputs are sampled then.
// -----------------------------------------------------------------------------
module tb_cpu_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n0, rst_n1, run0, run1;

   cpu_seq_ctrl_if imem0 ();
   cpu_seq_ctrl_if imem1 ();

   logic [4:0]  rs1_0, rd_0, rs1_1, rd_1;
   logic        we_0, we_1;
   logic [2:0]  op_0, op_1;
   logic [11:0] imm_0, imm_1;
   logic [31:0] pc_0, pc_1, ir_0, ir_1;
   logic        halt_0, halt_1, ill_0, ill_1;

   cpu_seq_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut0 (
      .clk(clk), .rst_n(rst_n0), .run(run0), .imem(imem0),
      .rf_rs1(rs1_0), .rf_rd(rd_0), .rf_we(we_0), .alu_op(op_0), .imm12(imm_0),
      .pc(pc_0), .instret(ir_0), .halted(halt_0), .illegal(ill_0)
   );

   cpu_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut1 (
      .clk(clk), .rst_n(rst_n1), .run(run1), .imem(imem1),
      .rf_rs1(rs1_1), .rf_rd(rd_1), .rf_we(we_1), .alu_op(op_1), .imm12(imm_1),
      .pc(pc_1), .instret(ir_1), .halted(halt_1), .illegal(ill_1)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n0 = 1'b0; rst_n1 = 1'b0; run0 = 1'b1; run1 = 1'b1;
      imem0.ack = 1'b0; imem0.rdata = '0;
      imem1.ack = 1'b0; imem1.rdata = '0;
      repeat (3) step();

      // ---------------- reset state ----------------
      check_eq("rst_pc",      pc_0,      32'h0);
      check_eq("rst_req",     imem0.req, 32'h0);
      check_eq("rst_we",      we_0,      32'h0);
      check_eq("rst_instret", ir_0,      32'h0);
      check_eq("rst_halted",  halt_0,    32'h0);
      check_eq("rst_illegal", ill_0,     32'h0);
      check_eq("rst_aluop",   op_0,      32'h0);
      check_eq("rst_imm",     imm_0,     32'h0);
      check_eq("rst_rd",      rd_0,      32'h0);

      rst_n0 = 1'b1; #1;
      check_eq("rel_req",  imem0.req,  32'h1);
      check_eq("rel_addr", imem0.addr, 32'h0);

      // ---------------- ADDI x1,x0,5, ack with req ----------------
      imem0.ack = 1'b1; imem0.rdata = 32'h0050_0093;
      step();
      imem0.ack = 1'b0; imem0.rdata = '0; #1;
      check_eq("dec_we",    we_0,      32'h0);
      check_eq("dec_req",   imem0.req, 32'h0);
      check_eq("dec_aluop", op_0,      32'h0);
      step();
      check_eq("ex_aluop", op_0,  32'h1);
      check_eq("ex_imm",   imm_0, 32'h005);
      check_eq("ex_rd",    rd_0,  32'h1);
      check_eq("ex_rs1",   rs1_0, 32'h0);
      check_eq("ex_we",    we_0,  32'h0);
      step();
      check_eq("wb_we",    we_0,  32'h1);
      check_eq("wb_aluop", op_0,  32'h1);
      check_eq("wb_rd",    rd_0,  32'h1);
      check_eq("wb_pc",    pc_0,  32'h0);
      step();
      check_eq("f2_we",      we_0,       32'h0);
      check_eq("f2_pc",      pc_0,       32'h4);
      check_eq("f2_instret", ir_0,       32'h1);
      check_eq("f2_aluop",   op_0,       32'h0);
      check_eq("f2_req",     imem0.req,  32'h1);
      check_eq("f2_addr",    imem0.addr, 32'h4);
      $display("[TB] dut0 retired ADDI x1,x0,5 -> pc=%h instret=%0d", pc_0, ir_0);

      // ---------------- spurious ack with run=0 ----------------
      run0 = 1'b0; imem0.ack = 1'b1; imem0.rdata = 32'h0010_0073; #1;
      check_eq("sp_req", imem0.req, 32'h0);
      step();
      run0 = 1'b1; imem0.ack = 1'b0; imem0.rdata = '0; #1;
      check_eq("sp_noload_req",  imem0.req,  32'h1);
      check_eq("sp_noload_addr", imem0.addr, 32'h4);
      check_eq("sp_halted",      halt_0,     32'h0);
      $display("[TB] dut0 spurious ack with run=0 ignored");

      // ---------------- ack delayed 3 cycles ----------------
      for (int i = 0; i < 3; i++) begin
         check_eq("dly_req",  imem0.req,  32'h1);
         check_eq("dly_addr", imem0.addr, 32'h4);
         step();
      end
      imem0.ack = 1'b1; imem0.rdata = 32'h0070_8113; #1;   // ADDI x2,x1,7
      check_eq("dly_req4",  imem0.req,  32'h1);
      check_eq("dly_addr4", imem0.addr, 32'h4);
      step();
      imem0.ack = 1'b0; imem0.rdata = '0; #1;
      check_eq("dly_dec_we", we_0, 32'h0);
      step();
      check_eq("dly_ex_we",  we_0,  32'h0);
      check_eq("dly_ex_rs1", rs1_0, 32'h1);
      check_eq("dly_ex_rd",  rd_0,  32'h2);
      check_eq("dly_ex_imm", imm_0, 32'h007);
      step();
      check_eq("dly_wb_we", we_0, 32'h1);
      step();
      check_eq("dly_pc",      pc_0, 32'h8);
      check_eq("dly_instret", ir_0, 32'h2);
      $display("[TB] dut0 retired ADDI x2,x1,7 -> pc=%h instret=%0d", pc_0, ir_0);

      // ---------------- EBREAK at pc=8 ----------------
      imem0.ack = 1'b1; imem0.rdata = 32'h0010_0073;
      step();
      imem0.ack = 1'b0; imem0.rdata = '0;
      step();
      check_eq("eb_halted",  halt_0, 32'h1);
      check_eq("eb_illegal", ill_0,  32'h0);
      check_eq("eb_pc",      pc_0,   32'h8);
      check_eq("eb_aluop",   op_0,   32'h0);
      for (int i = 0; i < 22; i++) begin
         imem0.ack = i[0];
         step();
         check_eq("eb_req",     imem0.req, 32'h0);
         check_eq("eb_we",      we_0,      32'h0);
         check_eq("eb_hold_pc", pc_0,      32'h8);
         check_eq("eb_instret", ir_0,      32'h2);
         check_eq("eb_sticky",  halt_0,    32'h1);
      end
      imem0.ack = 1'b0;
      $display("[TB] dut0 EBREAK halt at pc=%h", pc_0);

      // ---------------- illegal instruction ----------------
      rst_n0 = 1'b0; #1;
      check_eq("ill_rst_halted", halt_0, 32'h0);
      check_eq("ill_rst_pc",     pc_0,   32'h0);
      step();
      rst_n0 = 1'b1;
      imem0.ack = 1'b1; imem0.rdata = 32'h0000_0033;
      step();
      imem0.ack = 1'b0; imem0.rdata = '0;
      step();
      check_eq("ill_halted",  halt_0, 32'h1);
      check_eq("ill_illegal", ill_0,  32'h1);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("ill_we",      we_0,   32'h0);
         check_eq("ill_instret", ir_0,   32'h0);
         check_eq("ill_sticky",  ill_0,  32'h1);
      end
      rst_n0 = 1'b0; #1;
      check_eq("ill_clr_halted",  halt_0, 32'h0);
      check_eq("ill_clr_illegal", ill_0,  32'h0);
      $display("[TB] dut0 illegal 0x00000033 flagged and cleared by reset");

      // ---------------- dut1: reset during EXEC ----------------
      step();
      rst_n1 = 1'b1; #1;
      check_eq("d1_req",  imem1.req,  32'h1);
      check_eq("d1_addr", imem1.addr, 32'hFFFF_FFFC);
      imem1.ack = 1'b1; imem1.rdata = 32'h0010_0193;         // ADDI x3,x0,1
      step();
      imem1.ack = 1'b0; imem1.rdata = '0;
      step();
      check_eq("d1_ex_aluop", op_1, 32'h1);
      check_eq("d1_ex_rd",    rd_1, 32'h3);
      #3 rst_n1 = 1'b0;
      #1;
      check_eq("d1_ar_aluop",   op_1,      32'h0);
      check_eq("d1_ar_imm",     imm_1,     32'h0);
      check_eq("d1_ar_rd",      rd_1,      32'h0);
      check_eq("d1_ar_we",      we_1,      32'h0);
      check_eq("d1_ar_req",     imem1.req, 32'h0);
      check_eq("d1_ar_pc",      pc_1,      32'hFFFF_FFFC);
      check_eq("d1_ar_instret", ir_1,      32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("d1_ar_hold_we", we_1, 32'h0);
         check_eq("d1_ar_hold_ir", ir_1, 32'h0);
      end
      $display("[TB] dut1 reset during EXEC discarded partial instruction");

      // ---------------- dut1: PC wrap ----------------
      rst_n1 = 1'b1;
      imem1.ack = 1'b1; imem1.rdata = 32'h0010_0193;
      step();
      imem1.ack = 1'b0; imem1.rdata = '0;
      step();
      step();
      check_eq("d1_wb_we", we_1, 32'h1);
      step();
      check_eq("d1_wrap_addr",    imem1.addr, 32'h0);
      check_eq("d1_wrap_pc",      pc_1,       32'h0);
      check_eq("d1_wrap_instret", ir_1,       32'h1);
      check_eq("d1_wrap_req",     imem1.req,  32'h1);
      $display("[TB] dut1 retired ADDI at 0xFFFFFFFC -> pc=%h instret=%0d", pc_1, ir_1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
